// File: rtl/tx_pkg.sv
// Shared types and helpers for the transmit byte-to-word packer.
// Lane placement lives here so that the RX path can reuse the same rule.
package tx_pkg;

  localparam int TX_BYTES_PER_WORD = 4;

  typedef logic [31:0] tx_word_t;

  typedef enum logic {
    FILL,
    PAD
  } packer_state_e;

  // Place byte b into lane k of word w.
  function automatic tx_word_t lane_put(tx_word_t w, logic [1:0] k, logic [7:0] b, bit msb_first);
    int sh;
    sh = msb_first ? (24 - 8 * int'(k)) : (8 * int'(k));
    return (w & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small first-word-fall-through FIFO; the head entry is always visible on dout.
// Occupancy is the difference of two wrap-around counters one bit wider than the pointers.
module sync_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_reg;
  logic [AW:0]      wr_cnt_reg;
  logic [AW:0]      rd_cnt_reg;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign wr_ptr  = wr_cnt_reg[AW-1:0];
  assign rd_ptr  = rd_cnt_reg[AW-1:0];
  assign level   = wr_cnt_reg - rd_cnt_reg;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Once drained, keep showing the word that was popped last.
  assign dout    = empty ? last_reg : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
      last_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_cnt_reg  <= wr_cnt_reg + 1'b1;
      end
      if (do_pop) begin
        last_reg   <= mem[rd_ptr];
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  assert property (@(posedge clk) disable iff (!rst_n) level <= (AW + 1)'(DEPTH));

endmodule

// File: rtl/tx_word_packer.sv
// Packs an accepted byte stream four bytes at a time into 32-bit words and buffers them.
// Partial words are padded out on a flush pulse or after an idle timeout.
module tx_word_packer
  import tx_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         TIMEOUT_CYC = 1000,
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter bit         MSB_FIRST   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            Tx_data,
  output logic                   Tx_valid,
  input  logic                   Tx_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   partial
);

  localparam int       TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam tx_word_t PAD_WORD = {TX_BYTES_PER_WORD{PAD_BYTE}};

  packer_state_e state_reg, state_next;
  logic [1:0]    byte_cnt_reg, byte_cnt_next;
  tx_word_t      word_reg, word_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          run_reg;

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  tx_word_t      push_word;
  tx_word_t      filled;
  logic [2:0]    fill_cnt;
  logic          timed_out;

  // run_reg holds in_ready low until the first clock after reset release.
  assign in_ready  = run_reg && (state_reg == FILL) && !full;
  assign accept    = in_valid && in_ready;
  assign filled    = accept ? lane_put(word_reg, byte_cnt_reg, in_data, MSB_FIRST) : word_reg;
  assign fill_cnt  = {1'b0, byte_cnt_reg} + {2'b00, accept};
  assign timed_out = (TIMEOUT_CYC != 0) && !accept && (byte_cnt_reg != 2'd0) && (timer_reg == TMAX);
  assign partial   = (byte_cnt_reg != 2'd0);
  assign Tx_valid  = !empty;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    word_next     = word_reg;
    timer_next    = timer_reg;
    push          = 1'b0;
    push_word     = word_reg;
    case (state_reg)
      FILL: begin
        if (fill_cnt == 3'd4) begin
          push          = 1'b1;
          push_word     = filled;
          byte_cnt_next = 2'd0;
          word_next     = PAD_WORD;
          timer_next    = '0;
        end else if ((fill_cnt != 3'd0) && (flush || timed_out)) begin
          if (!full) begin
            push          = 1'b1;
            push_word     = filled;
            byte_cnt_next = 2'd0;
            word_next     = PAD_WORD;
            timer_next    = '0;
          end else begin
            state_next    = PAD;
            word_next     = filled;
            byte_cnt_next = fill_cnt[1:0];
          end
        end else begin
          word_next     = filled;
          byte_cnt_next = fill_cnt[1:0];
          if (accept)
            timer_next = '0;
          else if ((TIMEOUT_CYC != 0) && (byte_cnt_reg != 2'd0) && (timer_reg < TMAX))
            timer_next = timer_reg + 1'b1;
        end
      end
      PAD: begin
        if (!full) begin
          push          = 1'b1;
          push_word     = word_reg;
          byte_cnt_next = 2'd0;
          word_next     = PAD_WORD;
          timer_next    = '0;
          state_next    = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      byte_cnt_reg <= 2'd0;
      word_reg     <= PAD_WORD;
      timer_reg    <= '0;
      run_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      word_reg     <= word_next;
      timer_reg    <= timer_next;
      run_reg      <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_word),
    .pop   (Tx_valid && Tx_ready),
    .dout  (Tx_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
